// File: rtl/raster_engine_if.sv
// Bus bundle for the raster engine.
// Carries the fill/line drawer handshakes, the line endpoints, the external
// back-buffer write port, the front-buffer read port and the swap strobe.
//   master : control side (drives requests, endpoints, writes, reads, swap)
//   slave  : raster_engine (drives ready flags and read data)
interface raster_engine_if #(
  parameter int unsigned HOR_ACTIVE_PIXELS = 640,
  parameter int unsigned VER_ACTIVE_PIXELS = 480
);
  localparam int unsigned X_W    = $clog2(HOR_ACTIVE_PIXELS);
  localparam int unsigned Y_W    = $clog2(VER_ACTIVE_PIXELS);
  localparam int unsigned PIXELS = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS;
  localparam int unsigned A_W    = $clog2(PIXELS);

  logic           fill_start;
  logic           fill_ready;
  logic [X_W-1:0] line_x1;
  logic [Y_W-1:0] line_y1;
  logic [X_W-1:0] line_x2;
  logic [Y_W-1:0] line_y2;
  logic           line_start;
  logic           line_ready;
  logic           ext_write_enable;
  logic [A_W-1:0] ext_write_addr;
  logic           ext_write_data;
  logic [A_W-1:0] read_addr;
  logic           read_data;
  logic           swap;

  modport master (
    output fill_start, line_x1, line_y1, line_x2, line_y2, line_start,
           ext_write_enable, ext_write_addr, ext_write_data, read_addr, swap,
    input  fill_ready, line_ready, read_data
  );

  modport slave (
    input  fill_start, line_x1, line_y1, line_x2, line_y2, line_start,
           ext_write_enable, ext_write_addr, ext_write_data, read_addr, swap,
    output fill_ready, line_ready, read_data
  );
endinterface

// File: rtl/raster_engine.sv
// Double-buffered 1-bpp frame buffer with a full-screen clear drawer and a
// Bresenham line drawer. Drawers and the external port write the back bank;
// the read port returns front-bank pixels one cycle after the address.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : raster_engine_if slave (handshakes, endpoints, ext write, read, swap)
module raster_engine #(
  parameter int unsigned HOR_ACTIVE_PIXELS = 640,
  parameter int unsigned VER_ACTIVE_PIXELS = 480
) (
  input  logic            clk,
  input  logic            rst_n,
  raster_engine_if.slave  bus
);
  localparam int unsigned X_W    = $clog2(HOR_ACTIVE_PIXELS);
  localparam int unsigned Y_W    = $clog2(VER_ACTIVE_PIXELS);
  localparam int unsigned PIXELS = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS;
  localparam int unsigned A_W    = $clog2(PIXELS);
  localparam int unsigned D_W    = X_W + Y_W + 2;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  function automatic logic [A_W-1:0] pix_addr(input logic signed [D_W-1:0] x,
                                               input logic signed [D_W-1:0] y);
    return A_W'(y) * A_W'(HOR_ACTIVE_PIXELS) + A_W'(x);
  endfunction

  // ---------------------------------------------------------------- fill
  state_t         fill_state;
  logic           fill_we;
  logic [A_W-1:0] fill_addr;
  logic           fill_data;

  assign fill_data = 1'b0;

  // Sweep every address once, writing 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_state     <= S_IDLE;
      bus.fill_ready <= 1'b1;
      fill_we        <= 1'b0;
      fill_addr      <= '0;
    end else begin
      case (fill_state)
        S_IDLE: if (bus.fill_start) begin
          fill_state     <= S_RUN;
          bus.fill_ready <= 1'b0;
          fill_we        <= 1'b1;
          fill_addr      <= '0;
        end
        S_RUN: if (fill_addr == A_W'(PIXELS - 1)) begin
          fill_state     <= S_IDLE;
          bus.fill_ready <= 1'b1;
          fill_we        <= 1'b0;
          fill_addr      <= '0;
        end else begin
          fill_addr <= fill_addr + A_W'(1);
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- line
  state_t                 line_state;
  logic                   line_we;
  logic [A_W-1:0]         line_addr;
  logic                   line_data;
  logic signed [D_W-1:0]  cur_x, cur_y, end_x, end_y;
  logic signed [D_W-1:0]  dx, dy, sx, sy, err;

  // Setup values derived from the endpoint inputs at accept time.
  logic signed [D_W-1:0]  x1_s, y1_s, x2_s, y2_s, raw_dx, raw_dy;
  logic signed [D_W-1:0]  set_dx, set_dy, set_sx, set_sy;

  assign x1_s   = $signed(D_W'(bus.line_x1));
  assign y1_s   = $signed(D_W'(bus.line_y1));
  assign x2_s   = $signed(D_W'(bus.line_x2));
  assign y2_s   = $signed(D_W'(bus.line_y2));
  assign raw_dx = x2_s - x1_s;
  assign raw_dy = y2_s - y1_s;
  assign set_dx = raw_dx[D_W-1] ? -raw_dx : raw_dx;
  assign set_dy = raw_dy[D_W-1] ? raw_dy : -raw_dy;
  assign set_sx = (x1_s < x2_s) ? D_W'(1) : {D_W{1'b1}};
  assign set_sy = (y1_s < y2_s) ? D_W'(1) : {D_W{1'b1}};

  // One Bresenham step; both tests use e2 from the pre-step error.
  logic signed [D_W-1:0]  e2, nxt_x, nxt_y, nxt_err;

  always_comb begin
    e2      = err <<< 1;
    nxt_x   = cur_x;
    nxt_y   = cur_y;
    nxt_err = err;
    if (e2 >= dy) begin
      nxt_err = nxt_err + dy;
      nxt_x   = cur_x + sx;
    end
    if (e2 <= dx) begin
      nxt_err = nxt_err + dx;
      nxt_y   = cur_y + sy;
    end
  end

  // Write the current point each RUN cycle; stop once the endpoint is written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_state     <= S_IDLE;
      bus.line_ready <= 1'b1;
      line_we        <= 1'b0;
      line_addr      <= '0;
      line_data      <= 1'b0;
      cur_x          <= '0;
      cur_y          <= '0;
      end_x          <= '0;
      end_y          <= '0;
      dx             <= '0;
      dy             <= '0;
      sx             <= '0;
      sy             <= '0;
      err            <= '0;
    end else begin
      case (line_state)
        S_IDLE: if (bus.line_start) begin
          line_state     <= S_RUN;
          bus.line_ready <= 1'b0;
          line_we        <= 1'b1;
          line_data      <= 1'b1;
          line_addr      <= pix_addr(x1_s, y1_s);
          cur_x          <= x1_s;
          cur_y          <= y1_s;
          end_x          <= x2_s;
          end_y          <= y2_s;
          dx             <= set_dx;
          dy             <= set_dy;
          sx             <= set_sx;
          sy             <= set_sy;
          err            <= set_dx + set_dy;
        end
        S_RUN: if (cur_x == end_x && cur_y == end_y) begin
          line_state     <= S_IDLE;
          bus.line_ready <= 1'b1;
          line_we        <= 1'b0;
          line_data      <= 1'b0;
          line_addr      <= '0;
        end else begin
          cur_x     <= nxt_x;
          cur_y     <= nxt_y;
          err       <= nxt_err;
          line_addr <= pix_addr(nxt_x, nxt_y);
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- storage
  // Sources are ORed; the controller keeps them mutually exclusive.
  logic           wr_en;
  logic [A_W-1:0] wr_addr;
  logic           wr_data;

  assign wr_en   = fill_we   | line_we   | bus.ext_write_enable;
  assign wr_addr = fill_addr | line_addr | bus.ext_write_addr;
  assign wr_data = fill_data | line_data | bus.ext_write_data;

  logic front;
  logic bank0 [PIXELS];
  logic bank1 [PIXELS];

  // Back bank is the one not selected by front; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en && front)  bank0[wr_addr] <= wr_data;
    if (wr_en && !front) bank1[wr_addr] <= wr_data;
  end

  // Registered front-bank read and buffer swap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.read_data <= 1'b0;
      front         <= 1'b0;
    end else begin
      bus.read_data <= front ? bank1[bus.read_addr] : bank0[bus.read_addr];
      front         <= front ^ bus.swap;
    end
  end
endmodule

// File: tb/tb_raster_engine.sv
// Self-checking bench for raster_engine on a small 16x12 screen.
module tb_raster_engine;
  localparam int unsigned H   = 16;
  localparam int unsigned V   = 12;
  localparam int unsigned PIX = H * V;
  localparam int unsigned X_W = $clog2(H);
  localparam int unsigned Y_W = $clog2(V);
  localparam int unsigned A_W = $clog2(PIX);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  raster_engine_if #(.HOR_ACTIVE_PIXELS(H), .VER_ACTIVE_PIXELS(V)) bus ();

  raster_engine #(.HOR_ACTIVE_PIXELS(H), .VER_ACTIVE_PIXELS(V)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endfunction

  // Write monitor on the merged back-bank write port.
  typedef struct {
    int cyc;
    int addr;
    bit data;
  } wr_t;

  wr_t wq[$];
  int  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t w;
    if (rst_n === 1'b1 && dut.wr_en === 1'b1) begin
      w.cyc  = cyc;
      w.addr = int'(dut.wr_addr);
      w.data = dut.wr_data;
      wq.push_back(w);
    end
  end

  // Reference: two banks, a front pointer, and a software Bresenham.
  bit mbank [2][PIX];
  int mfront = 0;
  int exp_q[$];

  function automatic void model_write(int addr, bit data);
    mbank[1 - mfront][addr] = data;
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic void ref_line(int x1, int y1, int x2, int y2);
    int dx, dy, sx, sy, err, e2, x, y;
    exp_q.delete();
    dx  = iabs(x2 - x1);
    dy  = -iabs(y2 - y1);
    sx  = (x1 < x2) ? 1 : -1;
    sy  = (y1 < y2) ? 1 : -1;
    err = dx + dy;
    x   = x1;
    y   = y1;
    for (int k = 0; k < 4 * (H + V); k++) begin
      exp_q.push_back(y * int'(H) + x);
      if (x == x2 && y == y2) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endfunction

  task automatic pulse_swap();
    bus.swap = 1'b1;
    @(negedge clk);
    bus.swap = 1'b0;
    mfront   = 1 - mfront;
  endtask

  task automatic readback(string name);
    int bad = 0;
    for (int a = 0; a < int'(PIX); a++) begin
      bus.read_addr = A_W'(a);
      @(negedge clk);
      if (bus.read_data !== mbank[mfront][a]) bad++;
    end
    check(name, bad, 0);
  endtask

  task automatic wait_line(output int busy);
    busy = 0;
    while (bus.line_ready !== 1'b1 && busy < 4 * int'(H + V)) begin
      busy++;
      @(negedge clk);
    end
  endtask

  task automatic run_fill(string tag);
    int busy, bad;
    wq.delete();
    bus.fill_start = 1'b1;
    @(negedge clk);
    bus.fill_start = 1'b0;
    busy = 0;
    while (bus.fill_ready !== 1'b1 && busy < int'(PIX) + 50) begin
      busy++;
      @(negedge clk);
    end
    check({tag, "_busy"}, busy, PIX);
    check({tag, "_writes"}, wq.size(), PIX);
    bad = 0;
    foreach (wq[i]) if (wq[i].addr != i || wq[i].data != 1'b0) bad++;
    check({tag, "_order"}, bad, 0);
    for (int a = 0; a < int'(PIX); a++) model_write(a, 1'b0);
  endtask

  task automatic start_line(int x1, int y1, int x2, int y2);
    bus.line_x1    = X_W'(x1);
    bus.line_y1    = Y_W'(y1);
    bus.line_x2    = X_W'(x2);
    bus.line_y2    = Y_W'(y2);
    bus.line_start = 1'b1;
    @(negedge clk);
    bus.line_start = 1'b0;
  endtask

  // Compares the logged writes for one line against the reference.
  task automatic check_line(string tag, int x1, int y1, int x2, int y2, int busy);
    int n, bad;
    ref_line(x1, y1, x2, y2);
    n = ((iabs(x2 - x1) > iabs(y2 - y1)) ? iabs(x2 - x1) : iabs(y2 - y1)) + 1;
    check({tag, "_busy"}, busy, n);
    check({tag, "_count"}, wq.size(), n);
    bad = 0;
    foreach (wq[i]) begin
      if (i >= exp_q.size() || wq[i].addr != exp_q[i] || wq[i].data != 1'b1 ||
          wq[i].cyc != wq[0].cyc + i) bad++;
    end
    check({tag, "_pixels"}, bad, 0);
    foreach (exp_q[i]) model_write(exp_q[i], 1'b1);
  endtask

  typedef struct {
    int x1, y1, x2, y2;
    int n, first, last;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int busy, na, nb, bad;
    int x1, y1, x2, y2;

    tbl[0] = '{x1:0, y1:0, x2:3, y2:0, n:4, first:0,   last:3};
    tbl[1] = '{x1:5, y1:5, x2:2, y2:2, n:4, first:85,  last:34};
    tbl[2] = '{x1:0, y1:0, x2:1, y2:4, n:5, first:0,   last:65};
    tbl[3] = '{x1:7, y1:9, x2:7, y2:9, n:1, first:151, last:151};

    rst_n                = 1'b0;
    bus.fill_start       = 1'b0;
    bus.line_start       = 1'b0;
    bus.line_x1          = '0;
    bus.line_y1          = '0;
    bus.line_x2          = '0;
    bus.line_y2          = '0;
    bus.ext_write_enable = 1'b0;
    bus.ext_write_addr   = '0;
    bus.ext_write_data   = 1'b0;
    bus.read_addr        = '0;
    bus.swap             = 1'b0;

    // Reset
    @(negedge clk);
    @(negedge clk);
    check("rst_fill_ready", int'(bus.fill_ready), 1);
    check("rst_line_ready", int'(bus.line_ready), 1);
    check("rst_read_data", int'(bus.read_data), 0);
    check("rst_wr_en", int'(dut.wr_en), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", int'(bus.fill_ready & bus.line_ready), 1);
    check("post_rst_wr_en", int'(dut.wr_en), 0);

    // Clear both banks; check the cleared one reads all zero.
    run_fill("fill1");
    pulse_swap();
    readback("fill1_read");
    run_fill("fill2");

    // Directed line table
    for (int i = 0; i < 4; i++) begin
      wq.delete();
      start_line(tbl[i].x1, tbl[i].y1, tbl[i].x2, tbl[i].y2);
      wait_line(busy);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].n);
      check($sformatf("tbl%0d_count", i), wq.size(), tbl[i].n);
      check($sformatf("tbl%0d_first", i), (wq.size() > 0) ? wq[0].addr : -1, tbl[i].first);
      check($sformatf("tbl%0d_last", i), (wq.size() > 0) ? wq[wq.size()-1].addr : -1, tbl[i].last);
      check_line($sformatf("tbl%0d", i), tbl[i].x1, tbl[i].y1, tbl[i].x2, tbl[i].y2, busy);
    end
    pulse_swap();
    readback("tbl_read");
    bus.read_addr = A_W'(4);
    @(negedge clk);
    check("addr4_zero", int'(bus.read_data), 0);

    // Buffer isolation
    wq.delete();
    start_line(2, 10, 13, 3);
    wait_line(busy);
    check_line("iso", 2, 10, 13, 3, busy);
    readback("iso_before_swap");
    pulse_swap();
    readback("iso_after_swap");
    pulse_swap();
    readback("iso_second_swap");

    // Randomized lines and external writes
    for (int r = 0; r < 16; r++) begin
      x1 = int'($urandom_range(H - 1));
      y1 = int'($urandom_range(V - 1));
      x2 = int'($urandom_range(H - 1));
      y2 = int'($urandom_range(V - 1));
      wq.delete();
      start_line(x1, y1, x2, y2);
      wait_line(busy);
      check_line($sformatf("rnd%0d", r), x1, y1, x2, y2, busy);
    end
    for (int r = 0; r < 12; r++) begin
      int a;
      bit d;
      a = int'($urandom_range(PIX - 1));
      d = 1'($urandom_range(1));
      bus.ext_write_enable = 1'b1;
      bus.ext_write_addr   = A_W'(a);
      bus.ext_write_data   = d;
      @(negedge clk);
      model_write(a, d);
    end
    bus.ext_write_enable = 1'b0;
    bus.ext_write_addr   = '0;
    bus.ext_write_data   = 1'b0;
    pulse_swap();
    readback("rnd_read");

    // Busy start ignored, then back-to-back accept on first ready edge
    wq.delete();
    bus.line_x1 = X_W'(0);  bus.line_y1 = Y_W'(1);
    bus.line_x2 = X_W'(9);  bus.line_y2 = Y_W'(4);
    bus.line_start = 1'b1;
    @(negedge clk);
    bus.line_x1 = X_W'(12); bus.line_y1 = Y_W'(11);
    bus.line_x2 = X_W'(3);  bus.line_y2 = Y_W'(2);
    wait_line(busy);
    check("b2b_first_busy", busy, 10);
    @(negedge clk);
    bus.line_start = 1'b0;
    wait_line(busy);
    ref_line(0, 1, 9, 4);
    na = exp_q.size();
    bad = 0;
    for (int i = 0; i < na; i++) begin
      if (i >= wq.size() || wq[i].addr != exp_q[i]) bad++;
      model_write(exp_q[i], 1'b1);
    end
    check("b2b_first_pixels", bad, 0);
    ref_line(12, 11, 3, 2);
    nb = exp_q.size();
    check("b2b_total", wq.size(), na + nb);
    bad = 0;
    for (int i = 0; i < nb; i++) begin
      if (na + i >= wq.size() || wq[na + i].addr != exp_q[i]) bad++;
      model_write(exp_q[i], 1'b1);
    end
    check("b2b_second_pixels", bad, 0);
    check("b2b_gap", (wq.size() > na) ? wq[na].cyc - wq[na - 1].cyc : -1, 2);
    pulse_swap();
    readback("b2b_read");

    // Reset in the middle of a fill
    bus.fill_start = 1'b1;
    @(negedge clk);
    bus.fill_start = 1'b0;
    repeat (20) @(negedge clk);
    check("midfill_busy", int'(bus.fill_ready), 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midfill_rst_wr_en", int'(dut.wr_en), 0);
    check("midfill_rst_ready", int'(bus.fill_ready), 1);
    check("midfill_rst_read", int'(bus.read_data), 0);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midfill_no_restart", int'(dut.wr_en), 0);
    check("midfill_ready_held", int'(bus.fill_ready & bus.line_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/raster_engine.md
# raster_engine

Pixel-drawing back end of the function plotter: a double-buffered 1-bit-per-pixel frame buffer plus two hardware drawers, a full-screen clear (fill) and a Bresenham line rasterizer. Control logic clears the back buffer, draws lines into it, and pulses `swap` to present it. The VGA scan-out reads the front buffer. An external write port lets the symbol drawer share the back buffer.

## Interface
- `HOR_ACTIVE_PIXELS`, default 640: screen width.
- `VER_ACTIVE_PIXELS`, default 480: screen height.
- Derived values:
  - X_W = clog2(HOR_ACTIVE_PIXELS)
  - Y_W = clog2(VER_ACTIVE_PIXELS)
  - PIXELS = HOR_ACTIVE_PIXELS × VER_ACTIVE_PIXELS
  - A_W = clog2(PIXELS)
- `clk`  in  1  single clock. Everything is synchronous to its rising edge.
- `rst_n`  in  1  reset. Synchronous, active-low.
- `fill_start`  in  1  request a full clear of the back buffer.
- `fill_ready`  out  1  fill drawer idle.
- `line_x1`, `line_y1`, `line_x2`, `line_y2`  in  X_W/Y_W  line endpoints. Both endpoints are inclusive.
- `line_start`  in  1  request a line draw.
- `line_ready`  out  1  line drawer idle.
- `ext_write_enable`, `ext_write_addr`, `ext_write_data`  in  1/A_W/1  external pixel write into the back buffer.
- `read_addr`  in  A_W  front-buffer read address.
- `read_data`  out  1  front-buffer pixel.
- `swap`  in  1  exchange front and back buffers.

## Operation
- **Storage**
  - Two banks of PIXELS × 1 bit.
  - Pixel address = y·HOR_ACTIVE_PIXELS + x.
  - `front` register selects the bank that is read. The other bank is the back bank, which receives all writes.
  - Memory contents are not reset (block RAM).
- **Write merge**
  - Back-bank write enable, address and data are the bitwise OR of the fill, line and ext sources.
  - When idle, each internal drawer drives 0 on its write enable, address and data.
  - Control logic guarantees at most one source writes per cycle. Simultaneous writes produce the ORed value, and no arbitration is provided.
- **Fill drawer**
  - States: IDLE, RUN.
  - In IDLE with `fill_start`=1: go to RUN with counter = 0.
  - In RUN, each cycle: write data 0 at address = counter, then increment the counter.
  - After address PIXELS−1 is written, return to IDLE.
- **Line drawer**
  - States: IDLE, RUN.
  - In IDLE with `line_start`=1, latch the setup values:
    - dx = |x2−x1|, dy = −|y2−y1|
    - sx = sign(x2−x1), sy = sign(y2−y1)
    - err = dx+dy
    - current point = (x1, y1)
  - In RUN, each cycle:
    - Write 1 at the current point.
    - If the current point equals (x2, y2), return to IDLE.
    - Otherwise compute e2 = 2·err. If e2 ≥ dy: err += dy, x += sx. If e2 ≤ dx: err += dx, y += sy.
  - Arithmetic is signed, X_W+Y_W+2 bits wide, so it cannot overflow.
  - Pixels written = max(dx, |dy|) + 1. A zero-length line writes exactly one pixel.
  - Endpoints are not clipped. Callers supply on-screen coordinates.
- `start` while a drawer is not ready is ignored. Endpoint inputs are sampled only at accept.
- **Swap**: on a clock edge with `swap`=1, `front` toggles.

## Timing
- **Reset values**
  - `fill_ready` = `line_ready` = 1.
  - Internal write enables, addresses and data = 0.
  - `front` = 0.
  - `read_data` = 0.
  - An in-progress fill or line is aborted and its drawer returns to IDLE.
- **Start accept**: `start` is accepted at an edge where `ready`=1.
  - `ready` is 0 from the next cycle onward.
  - The first write is in that same cycle.
- **Fill timing**: write enable is high for exactly PIXELS consecutive cycles. `fill_ready` returns to 1 in the cycle after the last write.
- **Line timing**: write enable is high for exactly N = max(dx, |dy|) + 1 consecutive cycles. `line_ready` returns to 1 in the cycle after the last write.
- **Back-to-back starts**: a new `start` may be accepted at the first edge where `ready`=1 again.
- **Reads**: registered with 1-cycle latency. `read_data` at edge k+1 reflects `read_addr` at edge k, from the bank that was front at edge k.
- **Swap timing**
  - Writes in the same cycle as `swap` go to the pre-toggle back bank.
  - Reads issued on the edge after `swap` use the new front bank.
- **Read-during-write**: a read and a write in the same cycle always hit different banks, so there is no hazard.

## Test plan
- **Reset**: hold `rst_n`=0 for 2 cycles, then release.
  - Required: `fill_ready` = `line_ready` = 1, no write activity, `read_data` = 0.
- **Fill**: pulse `fill_start`.
  - Required: `fill_ready` low for 307200 cycles (at 640×480) and exactly 307200 writes of 0 at addresses 0..307199 in order.
  - Then pulse `swap`. Every `read_addr` must return 0.
- **Horizontal line**: line (0,0)→(3,0).
  - Required: writes at addresses 0, 1, 2, 3, then ready.
  - After `swap`, addresses 0–3 read 1 and address 4 reads 0.
- **Reversed diagonal and steep lines**
  - Line (5,5)→(2,2) writes (5,5), (4,4), (3,3), (2,2), i.e. addresses 3205, 2564, 1923, 1282.
  - Line (0,0)→(1,4) writes exactly 5 pixels with y = 0..4 and final x = 1.
  - Line (7,9)→(7,9) writes only address 5767.
- **Buffer isolation**: draw a line without `swap`.
  - Required: reads of those addresses return the old front contents.
  - After `swap` they read 1. After a second `swap` the original bank is visible again.
- **Busy and reset**
  - Assert `line_start` with new endpoints mid-line. Required: ignored, and the original pixel count is unchanged.
  - Assert `rst_n`=0 mid-fill. Required: next cycle write enable = 0 and `fill_ready` = 1.
